// File: rtl/sn74ls69_pkg.sv
// Shared SN74LS69 constants: default propagation delays and counter width.
// Used by both counter sections of the dual package.
package sn74ls69_pkg;

  localparam int TPD_CK_Q  = 10;
  localparam int TPD_CLR_Q = 20;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/sn74ls69_tff.sv
// Negative-edge toggle flip-flop, async active-low clear, optional Q delay.
// Delays are applied only when SN74LS69_II_DELAY_EN is defined.
module sn74ls69_tff #(
  parameter int TPD_CK  = 10,
  parameter int TPD_CLR = 20
) (
  input  logic clk_i,
  input  logic clr_n_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  if (TPD_CK < 0 || TPD_CLR < 0) begin : g_bad_tpd
    $error("sn74ls69_tff: negative delay");
  end

  // The next state is always the complement of the current one.
  always_comb begin
    q_d = ~q_q;
  end

  // Toggle on each falling edge; clear wins at any time.
  always_ff @(negedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

`ifdef SN74LS69_II_DELAY_EN
  logic q_dly;

  // Clear and clock paths see different propagation delays.
  always @(q_q) begin
    if (!clr_n_i) begin
      q_dly <= #(TPD_CLR) q_q;
    end else begin
      q_dly <= #(TPD_CK) q_q;
    end
  end

  assign q_o = q_dly;
`else
  assign q_o = q_q;
`endif

endmodule

// File: rtl/sn74ls69_ii.sv
// SN74LS69 section II: 4-bit ripple up-counter, falling-edge clocked.
// Define SN74LS69_II_DELAY_EN for per-stage propagation delays.
module sn74ls69_ii #(
  parameter int TPD_CK_Q  = sn74ls69_pkg::TPD_CK_Q,
  parameter int TPD_CLR_Q = sn74ls69_pkg::TPD_CLR_Q
) (
  input  logic clk,
  input  logic clr,
  output logic qa,
  output logic qb,
  output logic qc,
  output logic qd
);

  import sn74ls69_pkg::*;

  logic [CNT_W-1:0] q;

  // Each stage is clocked by the previous stage's Q; stage 0 by clk.
  for (genvar i = 0; i < CNT_W; i++) begin : g_stage
    logic stg_clk;

    if (i == 0) begin : g_first
      assign stg_clk = clk;
    end else begin : g_next
      assign stg_clk = q[i-1];
    end

    sn74ls69_tff #(
      .TPD_CK  (TPD_CK_Q),
      .TPD_CLR (TPD_CLR_Q)
    ) u_tff (
      .clk_i   (stg_clk),
      .clr_n_i (clr),
      .q_o     (q[i])
    );
  end

  assign qa = q[0];
  assign qb = q[1];
  assign qc = q[2];
  assign qd = q[3];

endmodule

// File: tb/tb_sn74ls69_ii.sv
// Directed plus randomized bench for sn74ls69_ii.
// Reference model is a plain modulo-16 integer count.
module tb_sn74ls69_ii;

  logic clk;
  logic clr;
  logic qa, qb, qc, qd;

  int n_tests;
  int n_fail;
  int mdl;
  bit mdl_valid;

  sn74ls69_ii dut (
    .clk (clk),
    .clr (clr),
    .qa  (qa),
    .qb  (qb),
    .qc  (qc),
    .qd  (qd)
  );

  function automatic logic [3:0] obs();
    return {qd, qc, qb, qa};
  endfunction

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] got;
    got = obs();
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply one stimulus step, update the model, wait 60 ns, compare.
  task automatic step(input logic c, input logic r, input string tag);
    if (!r) begin
      mdl = 0;
      mdl_valid = 1'b1;
    end else if (clk === 1'b1 && c === 1'b0) begin
      mdl = (mdl + 1) % 16;
    end
    clk = c;
    clr = r;
    #60;
    if (mdl_valid) check(tag, 4'(mdl));
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    mdl = 0;
    mdl_valid = 1'b0;
    clk = 1'b0;
    clr = 1'b1;
    #60;

    // Clear with clk high; must clear within TPD_CLR_Q.
    clk = 1'b1;
    clr = 1'b0;
    mdl = 0;
    mdl_valid = 1'b1;
    #25;
    check("clr_async", 4'b0000);
    #35;

    // Clock activity under clear is ignored.
    step(1'b0, 1'b0, "clr_hold_fall0");
    step(1'b1, 1'b0, "clr_hold_rise");
    step(1'b0, 1'b0, "clr_hold_fall");
    check("clr_hold_const", 4'b0000);

    // Release with clk low: no count until the next fall.
    step(1'b0, 1'b1, "release");
    check("release_const", 4'b0000);
    step(1'b1, 1'b1, "rise_after_rel");
    check("rise_const", 4'b0000);
    step(1'b0, 1'b1, "first_fall");
    check("first_fall_const", 4'b0001);

    // Re-clear, then 18 full cycles from zero.
    step(1'b0, 1'b0, "reclear");
    step(1'b0, 1'b1, "rerelease");
    for (int f = 1; f <= 18; f++) begin
      step(1'b1, 1'b1, "run_rise");
      step(1'b0, 1'b1, "run_fall");
      case (f)
        1:  check("fall1", 4'b0001);
        7:  check("fall7", 4'b0111);
        8:  check("fall8", 4'b1000);
        15: check("fall15", 4'b1111);
        16: check("fall16_wrap", 4'b0000);
        17: check("fall17", 4'b0001);
        18: check("fall18", 4'b0010);
        default: ;
      endcase
    end

    // Advance from 0010 to 1010, then clear with clk high.
    for (int f = 0; f < 8; f++) begin
      step(1'b1, 1'b1, "adv_rise");
      step(1'b0, 1'b1, "adv_fall");
    end
    check("at_1010", 4'b1010);
    step(1'b1, 1'b1, "pre_clr_rise");
    step(1'b1, 1'b0, "mid_clr");
    check("mid_clr_const", 4'b0000);
    step(1'b0, 1'b0, "fall_in_clr");
    check("fall_in_clr_const", 4'b0000);
    step(1'b0, 1'b1, "rand_release");

    // Random walk: change either clk or clr each step, never both.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        step(clk, ~clr, "rand_clr");
      end else if (clr == 1'b0 && $urandom_range(0, 1) == 0) begin
        step(clk, 1'b1, "rand_rel");
      end else begin
        step(~clk, clr, "rand_clk");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
